// File: rtl/peak_pair_hasher_if.sv
// Bus bundle between the peak picker, the pair hasher and the fingerprint store.
// The source side (master) drives frames and accepts hashes; the hasher is the slave.
`timescale 1ns/1ps
interface peak_pair_hasher_if #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 9,
  parameter int AMPL_WIDTH = 16,
  parameter int ZONE       = 3,
  parameter int TIME_WIDTH = 16
);
  localparam int DT_W   = $clog2(ZONE + 1);
  localparam int HASH_W = 2 * FREQ_WIDTH + DT_W;

  logic                                  valid_in;
  logic [PEAKS-1:0][AMPL_WIDTH-1:0]      amplitudes_in;
  logic [PEAKS-1:0][FREQ_WIDTH-1:0]      freqs_in;
  logic                                  frame_ready;
  logic [HASH_W-1:0]                     hash_out;
  logic [TIME_WIDTH-1:0]                 anchor_time;
  logic                                  hash_valid;
  logic                                  hash_ready;
  logic                                  overrun;

  modport master (
    output valid_in, amplitudes_in, freqs_in, hash_ready,
    input  frame_ready, hash_out, anchor_time, hash_valid, overrun
  );

  modport slave (
    input  valid_in, amplitudes_in, freqs_in, hash_ready,
    output frame_ready, hash_out, anchor_time, hash_valid, overrun
  );
endinterface

// File: rtl/peak_pair_hasher.sv
// Keeps the last ZONE+1 peak frames and streams {anchor_freq, target_freq, dt} pair hashes.
// Optional amplitude threshold: define PEAK_PAIR_HASHER_THRESH_EN to require amplitude >= MIN_AMPL.
`timescale 1ns/1ps
module peak_pair_hasher #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 9,
  parameter int AMPL_WIDTH = 16,
  parameter int ZONE       = 3,
  parameter int TIME_WIDTH = 16,
  parameter int MIN_AMPL   = 64
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  peak_pair_hasher_if.slave hif
);
  localparam int SLOTS  = ZONE + 1;
  localparam int DT_W   = $clog2(ZONE + 1);
  localparam int PTR_W  = $clog2(SLOTS);
  localparam int FILL_W = $clog2(SLOTS + 1);
  localparam int PEAK_W = (PEAKS > 1) ? $clog2(PEAKS) : 1;
  localparam int HASH_W = 2 * FREQ_WIDTH + DT_W;

`ifdef PEAK_PAIR_HASHER_THRESH_EN
  localparam int PRESENT_MIN = MIN_AMPL;
`else
  // Without the threshold any nonzero amplitude is a peak, i.e. amplitude >= 1.
  localparam int PRESENT_MIN = (MIN_AMPL != 0) ? 1 : 1;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [SLOTS-1:0][PEAKS-1:0][AMPL_WIDTH-1:0] ring_ampl_reg;
  logic [SLOTS-1:0][PEAKS-1:0][FREQ_WIDTH-1:0] ring_freq_reg;
  logic [SLOTS-1:0][PEAKS-1:0]                 present_mat;

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [FILL_W-1:0]     fill_reg;
  logic [FILL_W-1:0]     fill_next;
  logic [TIME_WIDTH-1:0] frame_cnt_reg;
  logic                  valid_prev_reg;
  logic                  overrun_reg;

  logic [1:0]            state_reg,      state_next;
  logic [PEAK_W-1:0]     a_reg,          a_next;
  logic [DT_W-1:0]       dt_reg,         dt_next;
  logic [PEAK_W-1:0]     t_reg,          t_next;
  logic [HASH_W-1:0]     hash_out_reg,   hash_out_next;
  logic [TIME_WIDTH-1:0] anchor_reg,     anchor_next;
  logic                  hash_valid_reg, hash_valid_next;

  logic                  rise;
  logic                  accept;
  logic                  drop;
  logic [PTR_W:0]        tgt_sum;
  logic [PTR_W-1:0]      tgt_slot;
  logic                  pair_present;
  logic                  last_combo;
  logic [PEAK_W-1:0]     a_adv;
  logic [DT_W-1:0]       dt_adv;
  logic [PEAK_W-1:0]     t_adv;

  assign rise   = hif.valid_in & ~valid_prev_reg;
  assign accept = rise & (state_reg == ST_IDLE);
  assign drop   = rise & (state_reg != ST_IDLE);

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    for (genvar gj = 0; gj < PEAKS; gj++) begin : g_peak
      assign present_mat[gi][gj] = (ring_ampl_reg[gi][gj] >= AMPL_WIDTH'(PRESENT_MIN));
    end
  end

  // Anchor is the oldest slot, which is exactly where the next frame will be written.
  always_comb begin
    tgt_sum = {1'b0, wr_ptr_reg} + (PTR_W + 1)'(dt_reg);
    if (tgt_sum >= (PTR_W + 1)'(SLOTS)) begin
      tgt_sum = tgt_sum - (PTR_W + 1)'(SLOTS);
    end
    tgt_slot = tgt_sum[PTR_W-1:0];
  end

  assign pair_present = present_mat[wr_ptr_reg][a_reg] & present_mat[tgt_slot][t_reg];
  assign last_combo   = (a_reg == PEAK_W'(PEAKS - 1)) && (dt_reg == DT_W'(ZONE)) &&
                        (t_reg == PEAK_W'(PEAKS - 1));

  // Iteration order: a outermost, then dt, then t innermost.
  always_comb begin
    a_adv  = a_reg;
    dt_adv = dt_reg;
    t_adv  = t_reg + PEAK_W'(1);
    if (t_reg == PEAK_W'(PEAKS - 1)) begin
      t_adv  = '0;
      dt_adv = dt_reg + DT_W'(1);
      if (dt_reg == DT_W'(ZONE)) begin
        dt_adv = DT_W'(1);
        a_adv  = a_reg + PEAK_W'(1);
      end
    end
  end

  assign fill_next = (fill_reg == FILL_W'(SLOTS)) ? fill_reg : fill_reg + FILL_W'(1);

  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    dt_next         = dt_reg;
    t_next          = t_reg;
    hash_out_next   = hash_out_reg;
    anchor_next     = anchor_reg;
    hash_valid_next = hash_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          a_next  = '0;
          dt_next = DT_W'(1);
          t_next  = '0;
          if (fill_next == FILL_W'(SLOTS)) begin
            state_next = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (pair_present) begin
          hash_out_next   = {ring_freq_reg[wr_ptr_reg][a_reg], ring_freq_reg[tgt_slot][t_reg], dt_reg};
          anchor_next     = frame_cnt_reg - TIME_WIDTH'(SLOTS);
          hash_valid_next = 1'b1;
          state_next      = ST_EMIT;
        end else if (last_combo) begin
          state_next = ST_IDLE;
        end else begin
          a_next  = a_adv;
          dt_next = dt_adv;
          t_next  = t_adv;
        end
      end
      ST_EMIT: begin
        if (hif.hash_ready) begin
          hash_valid_next = 1'b0;
          if (last_combo) begin
            state_next = ST_IDLE;
          end else begin
            a_next     = a_adv;
            dt_next    = dt_adv;
            t_next     = t_adv;
            state_next = ST_SCAN;
          end
        end
      end
      default: begin
        state_next      = ST_IDLE;
        hash_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      a_reg          <= '0;
      dt_reg         <= DT_W'(1);
      t_reg          <= '0;
      hash_out_reg   <= '0;
      anchor_reg     <= '0;
      hash_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      dt_reg         <= dt_next;
      t_reg          <= t_next;
      hash_out_reg   <= hash_out_next;
      anchor_reg     <= anchor_next;
      hash_valid_reg <= hash_valid_next;
    end
  end

  // Frame store: a dropped frame leaves ring, pointer and counter untouched.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ring_ampl_reg  <= '0;
      ring_freq_reg  <= '0;
      wr_ptr_reg     <= '0;
      fill_reg       <= '0;
      frame_cnt_reg  <= '0;
      valid_prev_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      valid_prev_reg <= hif.valid_in;
      if (drop) begin
        overrun_reg <= 1'b1;
      end
      if (accept) begin
        ring_ampl_reg[wr_ptr_reg] <= hif.amplitudes_in;
        ring_freq_reg[wr_ptr_reg] <= hif.freqs_in;
        wr_ptr_reg    <= (wr_ptr_reg == PTR_W'(ZONE)) ? '0 : wr_ptr_reg + PTR_W'(1);
        fill_reg      <= fill_next;
        frame_cnt_reg <= frame_cnt_reg + TIME_WIDTH'(1);
      end
    end
  end

  assign hif.frame_ready = (state_reg == ST_IDLE);
  assign hif.hash_out    = hash_out_reg;
  assign hif.anchor_time = anchor_reg;
  assign hif.hash_valid  = hash_valid_reg;
  assign hif.overrun     = overrun_reg;
endmodule

// File: tb/tb_peak_pair_hasher.sv
// Directed bench for peak_pair_hasher: warm-up, sparsity, backpressure, overrun, level hold, reset.
`timescale 1ns/1ps
module tb_peak_pair_hasher;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  peak_pair_hasher_if hif ();
  peak_pair_hasher dut (.CLOCK_50(clk), .reset(rst), .hif(hif));

  int checks = 0;
  int errors = 0;
  logic [19:0] hq [$];
  logic [15:0] aq [$];
  int stall_bad;

  function automatic logic [5:0][8:0] mk_freqs(input int f);
    logic [5:0][8:0] r;
    for (int p = 0; p < 6; p++) r[p] = 9'(f * 16 + p + 1);
    return r;
  endfunction

  function automatic logic [5:0][15:0] full_amps();
    logic [5:0][15:0] r;
    for (int p = 0; p < 6; p++) r[p] = 16'(100 + p);
    return r;
  endfunction

  // Expected stream for four consecutive frames base..base+3, all peaks present.
  function automatic int seq_errors(input int base);
    int n = 0;
    int k = 0;
    logic [19:0] e;
    for (int a = 0; a < 6; a++)
      for (int dt = 1; dt <= 3; dt++)
        for (int t = 0; t < 6; t++) begin
          e = {9'(base * 16 + a + 1), 9'((base + dt) * 16 + t + 1), 2'(dt)};
          if (k >= hq.size()) n++;
          else if (hq[k] !== e) n++;
          k++;
        end
    if (hq.size() > k) n += hq.size() - k;
    return n;
  endfunction

  function automatic int anchor_errors(input logic [15:0] e);
    int n = (aq.size() == 0) ? 1 : 0;
    foreach (aq[i]) if (aq[i] !== e) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    hif.valid_in = 1'b0;
    hif.hash_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Sends one frame and collects every accepted hash into hq/aq.
  task automatic send_frame(input logic [5:0][15:0] amps, input logic [5:0][8:0] freqs,
                            input int hold, input int stall, input int intrude, input int ready_mode);
    int cyc;
    bit stalled;
    logic [19:0] h0;
    logic [15:0] a0;
    hq.delete();
    aq.delete();
    stall_bad = 0;
    stalled = 1'b0;
    hif.valid_in = 1'b0;
    hif.hash_ready = 1'b0;
    @(negedge clk);
    hif.amplitudes_in = amps;
    hif.freqs_in = freqs;
    hif.valid_in = 1'b1;
    repeat (hold) @(negedge clk);
    hif.valid_in = 1'b0;
    cyc = 0;
    while (!(hif.frame_ready === 1'b1 && hif.hash_valid === 1'b0)) begin
      hif.valid_in = (cyc == intrude);
      if (hif.hash_valid === 1'b1) begin
        if (stall > 0 && !stalled) begin
          stalled = 1'b1;
          h0 = hif.hash_out;
          a0 = hif.anchor_time;
          hif.hash_ready = 1'b0;
          repeat (stall) begin
            @(negedge clk);
            if (hif.hash_valid !== 1'b1 || hif.hash_out !== h0 || hif.anchor_time !== a0) stall_bad++;
          end
          hif.valid_in = 1'b0;
        end
        hif.hash_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
        if (hif.hash_ready) begin
          hq.push_back(hif.hash_out);
          aq.push_back(hif.anchor_time);
        end
      end else begin
        hif.hash_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got no return to idle after %0d cycles, need idle", cyc);
        break;
      end
    end
    hif.valid_in = 1'b0;
    hif.hash_ready = 1'b0;
    $display("frame: hashes=%0d first_anchor=%0d overrun=%0b", hq.size(),
             (aq.size() > 0) ? aq[0] : 16'd0, hif.overrun);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (hif.frame_ready !== 1'b1) begin errors++; $display("FAIL rst_frame_ready: got %b need 1", hif.frame_ready); end
    checks++; if (hif.hash_valid !== 1'b0) begin errors++; $display("FAIL rst_hash_valid: got %b need 0", hif.hash_valid); end
    checks++; if (hif.hash_out !== 20'd0) begin errors++; $display("FAIL rst_hash_out: got %h need 0", hif.hash_out); end
    checks++; if (hif.anchor_time !== 16'd0) begin errors++; $display("FAIL rst_anchor_time: got %0d need 0", hif.anchor_time); end
    checks++; if (hif.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b need 0", hif.overrun); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_warmup();
    logic [19:0] e;
    int n;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      send_frame(full_amps(), mk_freqs(f), 1, 0, -1, 0);
      checks++; if (hq.size() !== 0) begin errors++; $display("FAIL warmup_no_hash: got %0d hashes need 0 (frame %0d)", hq.size(), f); end
      checks++; if (hif.frame_ready !== 1'b1) begin errors++; $display("FAIL warmup_ready: got %b need 1 (frame %0d)", hif.frame_ready, f); end
    end
    send_frame(full_amps(), mk_freqs(3), 1, 0, -1, 0);
    checks++; if (hq.size() !== 108) begin errors++; $display("FAIL warmup_count: got %0d need 108", hq.size()); end
    n = anchor_errors(16'd0);
    checks++; if (n !== 0) begin errors++; $display("FAIL warmup_anchor: got %0d bad anchors need 0", n); end
    e = {9'd1, 9'd17, 2'd1};
    checks++; if (hq[0] !== e) begin errors++; $display("FAIL warmup_first: got %h need %h", hq[0], e); end
    e = {9'd6, 9'd54, 2'd3};
    checks++; if (hq[$] !== e) begin errors++; $display("FAIL warmup_last: got %h need %h", hq[$], e); end
    n = seq_errors(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL warmup_sequence: got %0d bad hashes need 0", n); end
  endtask

  task automatic test_sparsity();
    logic [5:0][15:0] amps;
    logic [5:0][8:0] freqs;
    logic [19:0] e;
    do_reset();
    amps = '0;
    amps[2] = 16'd500;
    for (int f = 0; f < 4; f++) begin
      freqs = '0;
      freqs[2] = 9'(10 * (f + 1));
      send_frame(amps, freqs, 1, 0, -1, 0);
    end
    checks++; if (hq.size() !== 3) begin errors++; $display("FAIL sparse_count: got %0d need 3", hq.size()); end
    e = {9'd10, 9'd20, 2'd1};
    checks++; if (hq[0] !== e) begin errors++; $display("FAIL sparse_h0: got %h need %h", hq[0], e); end
    e = {9'd10, 9'd30, 2'd2};
    checks++; if (hq[1] !== e) begin errors++; $display("FAIL sparse_h1: got %h need %h", hq[1], e); end
    e = {9'd10, 9'd40, 2'd3};
    checks++; if (hq[2] !== e) begin errors++; $display("FAIL sparse_h2: got %h need %h", hq[2], e); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(full_amps(), mk_freqs(f), 1, 0, -1, 0);
    send_frame(full_amps(), mk_freqs(3), 1, 20, -1, 1);
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles need 0", stall_bad); end
    checks++; if (hq.size() !== 108) begin errors++; $display("FAIL bp_count: got %0d need 108", hq.size()); end
    n = seq_errors(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL bp_sequence: got %0d bad hashes need 0", n); end
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(full_amps(), mk_freqs(f), 1, 0, -1, 0);
    checks++; if (hif.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b need 0", hif.overrun); end
    send_frame(full_amps(), mk_freqs(3), 1, 0, 5, 0);
    checks++; if (hif.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b need 1", hif.overrun); end
    checks++; if (hq.size() !== 108) begin errors++; $display("FAIL ovr_count: got %0d need 108", hq.size()); end
    send_frame(full_amps(), mk_freqs(4), 1, 0, -1, 0);
    checks++; if (hif.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b need 1", hif.overrun); end
    checks++; if (aq[0] !== 16'd1) begin errors++; $display("FAIL ovr_anchor: got %0d need 1", aq[0]); end
    n = seq_errors(1);
    checks++; if (n !== 0) begin errors++; $display("FAIL ovr_sequence: got %0d bad hashes need 0", n); end
  endtask

  task automatic test_level_hold();
    int n;
    do_reset();
    send_frame(full_amps(), mk_freqs(0), 10, 0, -1, 0);
    checks++; if (hq.size() !== 0) begin errors++; $display("FAIL level_no_hash: got %0d need 0", hq.size()); end
    checks++; if (hif.frame_ready !== 1'b1) begin errors++; $display("FAIL level_ready: got %b need 1", hif.frame_ready); end
    for (int f = 1; f < 4; f++) send_frame(full_amps(), mk_freqs(f), 1, 0, -1, 0);
    checks++; if (hq.size() !== 108) begin errors++; $display("FAIL level_count: got %0d need 108", hq.size()); end
    checks++; if (aq[0] !== 16'd0) begin errors++; $display("FAIL level_anchor: got %0d need 0", aq[0]); end
    n = seq_errors(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL level_sequence: got %0d bad hashes need 0", n); end
  endtask

  task automatic test_reset_mid_emit();
    int waited;
    int total;
    int n;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(full_amps(), mk_freqs(f), 1, 0, -1, 0);
    hif.valid_in = 1'b0;
    @(negedge clk);
    hif.amplitudes_in = full_amps();
    hif.freqs_in = mk_freqs(3);
    hif.valid_in = 1'b1;
    @(negedge clk);
    hif.valid_in = 1'b0;
    waited = 0;
    while (hif.hash_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (hif.hash_valid !== 1'b1) begin errors++; $display("FAIL rme_emit_reached: got %b need 1", hif.hash_valid); end
    rst = 1'b1;
    #1;
    checks++; if (hif.hash_valid !== 1'b0) begin errors++; $display("FAIL rme_async_drop: got %b need 0", hif.hash_valid); end
    checks++; if (hif.frame_ready !== 1'b1) begin errors++; $display("FAIL rme_ready: got %b need 1", hif.frame_ready); end
    @(negedge clk);
    rst = 1'b0;
    total = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(full_amps(), mk_freqs(f + 8), 1, 0, -1, 0);
      total += hq.size();
    end
    checks++; if (total !== 0) begin errors++; $display("FAIL rme_warmup: got %0d hashes need 0", total); end
    send_frame(full_amps(), mk_freqs(11), 1, 0, -1, 0);
    checks++; if (aq[0] !== 16'd0) begin errors++; $display("FAIL rme_anchor: got %0d need 0", aq[0]); end
    n = seq_errors(8);
    checks++; if (n !== 0) begin errors++; $display("FAIL rme_sequence: got %0d bad hashes need 0", n); end
  endtask

  initial begin
    hif.valid_in = 1'b0;
    hif.amplitudes_in = '0;
    hif.freqs_in = '0;
    hif.hash_ready = 1'b0;
    test_reset();
    test_warmup();
    test_sparsity();
    test_backpressure();
    test_overrun();
    test_level_hold();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
